// File: rtl/sorting_pkg.sv
// Shared types and default sizes for the sorting datapath.
// Used by sorting_network and sorted_serializer.
package sorting_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_NUMBER_WIDTH   = 10;
    localparam int DEF_NUMBERS_AMOUNT = 10;

endpackage

// File: rtl/sorted_serializer.sv
// Serializes a sorted vector into one word per handshake.
// Define SORTED_SERIALIZER_DESC_EN to emit descending order.
module sorted_serializer
    import sorting_pkg::*;
#(
    parameter int NUMBER_WIDTH   = DEF_NUMBER_WIDTH,
    parameter int NUMBERS_AMOUNT = DEF_NUMBERS_AMOUNT,
    localparam int IDX_W         = $clog2(NUMBERS_AMOUNT)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i,
    input  logic                                      data_valid_i,
    output logic [NUMBER_WIDTH-1:0]                   data_o,
    output logic                                      data_valid_o,
    input  logic                                      data_ready_i,
    output logic                                      data_last_o,
    output logic [IDX_W-1:0]                          data_idx_o,
    output logic                                      overflow_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBERS_AMOUNT - 1);

    state_t                                      state;
    logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] buffer;
    logic [IDX_W-1:0]                            cnt;
    logic                                        overflow_q;

    logic             is_last;
    logic             hs;
    logic             last_hs;
    logic [IDX_W-1:0] sel;

    assign is_last = (state == SEND) && (cnt == LAST_IDX);
    assign hs      = (state == SEND) && data_ready_i;
    assign last_hs = hs && is_last;

`ifdef SORTED_SERIALIZER_DESC_EN
    assign sel = LAST_IDX - cnt;
`else
    assign sel = cnt;
`endif

    // Output view: all derived from registered state, so stable during stalls.
    always_comb begin
        data_valid_o = (state == SEND);
        data_last_o  = is_last;
        data_idx_o   = cnt;
        data_o       = '0;
        if (state == SEND) begin
            data_o = buffer[sel];
        end
        overflow_o   = overflow_q;
    end

    // Capture / count FSM; a new vector is only taken when idle or on the last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            buffer     <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_valid_i) begin
                        buffer <= data_i;
                        cnt    <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        cnt <= '0;
                        if (data_valid_i) begin
                            buffer <= data_i;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (hs) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (data_valid_i) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
